alu_uart_ctrl: RTL and testbench

//  Initiator side of the ALU operand/result interface.

---
 rtl/alu_uart_ctrl.sv | 149 ++++++++++++++
 tb/tb_alu_uart_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_uart_ctrl.sv
// alu_uart_ctrl: takes the A, B and OP bytes from the UART receiver and holds
// them on the ALU operand ports. It then sends the ALU result byte and a
// carry byte back to the UART transmitter.
module alu_uart_ctrl #(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned NB_OP   = NB_DATA - 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic [NB_DATA-1:0] o_dato_a,
  output logic [NB_DATA-1:0] o_dato_b,
  output logic [NB_OP-1:0]   o_op,
  input  logic [NB_DATA-1:0] i_alu_res,
  input  logic               i_alu_carry,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic               o_busy,
  output logic               o_overrun
);

  typedef enum logic [2:0] {
    RX_A     = 3'd0,
    RX_B     = 3'd1,
    RX_OP    = 3'd2,
    EXEC     = 3'd3,
    TX_RES   = 3'd4,
    WAIT_RES = 3'd5,
    TX_CY    = 3'd6,
    WAIT_CY  = 3'd7
  } state_t;

  state_t             state_q, state_d;
  logic [NB_DATA-1:0] dato_a_q, dato_a_d;
  logic [NB_DATA-1:0] dato_b_q, dato_b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               overrun_q, overrun_d;
  logic               carry_q, carry_d;
  logic               accepting;

  // A byte is accepted only in the three receive states
  always_comb begin
    accepting = (state_q == RX_A) || (state_q == RX_B) || (state_q == RX_OP);
  end

  // Next-state and datapath: the FSM makes at most one transition per edge
  always_comb begin
    state_d    = state_q;
    dato_a_d   = dato_a_q;
    dato_b_d   = dato_b_q;
    op_d       = op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    overrun_d  = overrun_q;
    carry_d    = carry_q;

    if (i_rx_valid && !accepting) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      RX_A: begin
        if (i_rx_valid) begin
          dato_a_d  = i_rx_data;
          overrun_d = 1'b0;
          state_d   = RX_B;
        end
      end
      RX_B: begin
        if (i_rx_valid) begin
          dato_b_d = i_rx_data;
          state_d  = RX_OP;
        end
      end
      RX_OP: begin
        if (i_rx_valid) begin
          op_d    = i_rx_data[NB_OP-1:0];
          state_d = EXEC;
        end
      end
      // The result is loaded straight into the TX register on the EXEC edge.
      // This keeps o_tx_data stable for the whole cycle in which the
      // registered start pulse is high.
      EXEC: begin
        tx_data_d  = i_alu_res;
        carry_d    = i_alu_carry;
        tx_start_d = 1'b1;
        state_d    = TX_RES;
      end
      TX_RES: begin
        state_d = WAIT_RES;
      end
      WAIT_RES: begin
        if (i_tx_done) begin
          tx_data_d  = {{(NB_DATA-1){1'b0}}, carry_q};
          tx_start_d = 1'b1;
          state_d    = TX_CY;
        end
      end
      TX_CY: begin
        state_d = WAIT_CY;
      end
      WAIT_CY: begin
        if (i_tx_done) begin
          state_d = RX_A;
        end
      end
      default: begin
        state_d = RX_A;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= RX_A;
      dato_a_q   <= '0;
      dato_b_q   <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      overrun_q  <= 1'b0;
      carry_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      dato_a_q   <= dato_a_d;
      dato_b_q   <= dato_b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      overrun_q  <= overrun_d;
      carry_q    <= carry_d;
    end
  end

  assign o_dato_a   = dato_a_q;
  assign o_dato_b   = dato_b_q;
  assign o_op       = op_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_overrun  = overrun_q;
  assign o_busy     = !accepting;

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Testbench for alu_uart_ctrl. Directed frames come from a table and a
// behavioural ALU closes the loop from the operand ports back to the result.
module tb_alu_uart_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] dato_a, dato_b;
  logic [5:0] op;
  logic [7:0] alu_res;
  logic       alu_carry;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_done;
  logic       busy;
  logic       overrun;

  int checks   = 0;
  int failures = 0;
  int starts   = 0;

  always #5 clk = ~clk;

  alu_uart_ctrl #(.NB_DATA(8), .NB_OP(6)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_rx_data   (rx_data),
    .i_rx_valid  (rx_valid),
    .o_dato_a    (dato_a),
    .o_dato_b    (dato_b),
    .o_op        (op),
    .i_alu_res   (alu_res),
    .i_alu_carry (alu_carry),
    .o_tx_data   (tx_data),
    .o_tx_start  (tx_start),
    .i_tx_done   (tx_done),
    .o_busy      (busy),
    .o_overrun   (overrun)
  );

  // Behavioural ALU; unknown opcodes return 0 with carry 0
  logic [8:0] alu_tmp;
  always_comb begin
    alu_tmp = '0;
    case (op)
      6'h20:   alu_tmp = {1'b0, dato_a} + {1'b0, dato_b};
      6'h22:   alu_tmp = {1'b0, dato_a} - {1'b0, dato_b};
      6'h24:   alu_tmp = {1'b0, dato_a & dato_b};
      6'h25:   alu_tmp = {1'b0, dato_a | dato_b};
      6'h26:   alu_tmp = {1'b0, dato_a ^ dato_b};
      6'h03:   alu_tmp = {1'b0, $signed(dato_a) >>> dato_b};
      6'h02:   alu_tmp = {1'b0, dato_a >> dato_b};
      6'h27:   alu_tmp = {1'b0, ~(dato_a | dato_b)};
      default: alu_tmp = '0;
    endcase
    alu_res   = alu_tmp[7:0];
    alu_carry = alu_tmp[8];
  end

  // Count every start pulse once (sampled away from the active edge)
  always @(negedge clk) if (tx_start) starts++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  a, b, opb;
    logic [5:0]  exp_op;
    logic [7:0]  exp_res, exp_cy;
    int unsigned dly;
    bit          ovr;     // inject a byte while waiting for the result TX
    bit          early;   // pulse i_tx_done together with the first o_tx_start
    bit          rst_mid; // reset after A,B of a dummy frame first
  } vec_t;

  vec_t tbl[7];

  task automatic run_frame(input vec_t v);
    int s0;
    s0 = starts;
    send_byte(v.a);
    chk("overrun_clr_on_A", overrun, 0);
    chk("dato_a", dato_a, v.a);
    chk("busy_rx_a", busy, 0);
    send_byte(v.b);
    chk("dato_b", dato_b, v.b);
    send_byte(v.opb);
    chk("op", op, v.exp_op);
    chk("busy_exec", busy, 1);
    chk("start_in_exec", tx_start, 0);
    @(negedge clk);
    chk("start1", tx_start, 1);
    chk("tx_res", tx_data, v.exp_res);
    if (v.early) tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("start1_one_cycle", tx_start, 0);
    chk("tx_res_hold", tx_data, v.exp_res);
    if (v.ovr) begin
      send_byte(8'h01);
      chk("overrun_set", overrun, 1);
      chk("dato_a_after_ovr", dato_a, v.a);
      chk("busy_after_ovr", busy, 1);
    end
    repeat (v.dly) @(negedge clk);
    chk("tx_res_held_wait", tx_data, v.exp_res);
    chk("starts_before_done", starts - s0, 1);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("start2", tx_start, 1);
    chk("tx_cy", tx_data, v.exp_cy);
    @(negedge clk);
    chk("start2_one_cycle", tx_start, 0);
    chk("busy_wait_cy", busy, 1);
    repeat (3) @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("busy_idle", busy, 0);
    chk("starts_per_frame", starts - s0, 2);
    if (v.ovr) chk("overrun_sticky", overrun, 1);
  endtask

  initial begin
    //          a      b      op     exp_op exp_res exp_cy dly   ovr early rst
    tbl[0] = '{8'h05, 8'h03, 8'h20, 6'h20, 8'h08, 8'h00, 2,    0, 0, 0}; // ADD
    tbl[1] = '{8'h03, 8'h05, 8'h22, 6'h22, 8'hFE, 8'h01, 2,    0, 0, 0}; // SUB borrow
    tbl[2] = '{8'hF0, 8'h0F, 8'hE7, 6'h27, 8'h00, 8'h00, 2,    0, 0, 0}; // NOR, top bits dropped
    tbl[3] = '{8'h10, 8'h22, 8'h20, 6'h20, 8'h32, 8'h00, 4,    1, 0, 0}; // overrun in WAIT_RES
    tbl[4] = '{8'h0C, 8'h0A, 8'h24, 6'h24, 8'h08, 8'h00, 2,    0, 0, 1}; // AND after mid reset
    tbl[5] = '{8'hFF, 8'h01, 8'h20, 6'h20, 8'h00, 8'h01, 1000, 0, 1, 0}; // slow TX, carry out
    tbl[6] = '{8'h12, 8'h34, 8'h3F, 6'h3F, 8'h00, 8'h00, 2,    0, 0, 0}; // unknown op

    rst_n    = 1'b0;
    rx_data  = '0;
    rx_valid = 1'b0;
    tx_done  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dato_a", dato_a, 0);
    chk("rst_dato_b", dato_b, 0);
    chk("rst_op", op, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_start", tx_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // A stray done while idle must not start anything
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_done_no_start", starts, 0);

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].rst_mid) begin
        send_byte(8'h77);
        send_byte(8'h66);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_dato_a", dato_a, 0);
        chk("midrst_dato_b", dato_b, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_tx_data", tx_data, 0);
        rst_n = 1'b1;
        @(negedge clk);
      end
      run_frame(tbl[i]);
      chk("frame_hold_a", dato_a, tbl[i].a);
    end

    // Extra done pulses in RX_A: no spurious transmission
    begin
      int s0;
      s0 = starts;
      repeat (2) begin
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        @(negedge clk);
      end
      repeat (4) @(negedge clk);
      chk("extra_done_no_start", starts - s0, 0);
      chk("extra_done_busy", busy, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
